// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_pkg
// Description : Shared constants, region type and byte-lane merge helper for
//               the CPU data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_responder_pkg;

    // Default value of addr[31:28] that selects the MMIO region
    localparam logic [3:0]  c_mmio_tag_default = 4'h1;

    // MMIO register byte offsets (addr[7:0])
    localparam logic [7:0]  c_timer_count_off  = 8'h00;
    localparam logic [7:0]  c_timer_cmp_off    = 8'h04;
    localparam logic [7:0]  c_timer_stat_off   = 8'h08;
    localparam logic [7:0]  c_gpio_out_off     = 8'h0C;

    // TIMER_STAT bit positions
    localparam int          c_stat_pend_bit    = 0;
    localparam int          c_stat_en_bit      = 1;

    typedef enum logic {
        REGION_RAM  = 1'b0,
        REGION_MMIO = 1'b1
    } region_e;

    // Replace the bytes of old_word whose lane-select bit is set.
    // sel[i] covers bits [8*i+7:8*i]; sel[3] is the byte at address offset 00.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  sel
    );
        logic [31:0] mask;
        mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return (old_word & ~mask) | (new_word & mask);
    endfunction

endpackage : data_mem_responder_pkg
`default_nettype wire

// File: rtl/data_mem_responder_mmio_timer.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_mmio_timer
// Description : Free-running 32-bit timer with compare match, sticky pending
//               flag (write-1-to-clear) and enable bit.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder_mmio_timer
    import data_mem_responder_pkg::*;
#(
    parameter logic [31:0] TIMER_RST = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_count,
    input  logic        wr_cmp,
    input  logic        wr_stat,
    input  logic [3:0]  sel,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] cmp,
    output logic        pending,
    output logic        enable,
    output logic        timer_irq
);

    logic [31:0] r_count;
    logic [31:0] r_cmp;
    logic        r_pending;
    logic        r_enable;
    logic        w_match;
    logic        w_stat_lane0;

    // Match compares the values held before this edge, so a CMP or COUNT
    // write in the same cycle does not affect it.
    assign w_match      = r_enable && (r_count == r_cmp);
    assign w_stat_lane0 = wr_stat && sel[0];

    // Timer state: reset, then COUNT write beats increment, match beats W1C
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= TIMER_RST;
            r_cmp     <= '1;
            r_pending <= 1'b0;
            r_enable  <= 1'b0;
        end else begin
            if (wr_count) begin
                r_count <= lane_merge(r_count, wdata, sel);
            end else if (r_enable) begin
                r_count <= r_count + 32'd1;
            end

            if (wr_cmp) begin
                r_cmp <= lane_merge(r_cmp, wdata, sel);
            end

            if (w_stat_lane0) begin
                r_enable <= wdata[c_stat_en_bit];
            end

            if (w_match) begin
                r_pending <= 1'b1;
            end else if (w_stat_lane0 && wdata[c_stat_pend_bit]) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign count     = r_count;
    assign cmp       = r_cmp;
    assign pending   = r_pending;
    assign enable    = r_enable;
    assign timer_irq = r_pending;

endmodule : data_mem_responder_mmio_timer
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Target side of the CPU data-memory port. Decodes accesses to
//               a word-organised RAM with byte-lane writes or a small MMIO
//               file (timer + GPIO). Read data is combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          RAM_AW    = 12,
    parameter logic [3:0]  MMIO_TAG  = c_mmio_tag_default,
    parameter logic [31:0] TIMER_RST = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ram_ce_i,
    input  logic        ram_we_i,
    input  logic [31:0] ram_addr_i,
    input  logic [3:0]  ram_sel_i,
    input  logic [31:0] ram_data_i,
    output logic [31:0] ram_data_o,
    output logic        timer_irq_o,
    output logic [31:0] gpio_o
);

    localparam int c_ram_depth = 1 << RAM_AW;

    logic [31:0]       r_mem [c_ram_depth];
    logic [31:0]       r_gpio;

    region_e           w_region;
    logic              w_access;
    logic              w_store;
    logic [RAM_AW-1:0] w_word_idx;
    logic [5:0]        w_mmio_word;
    logic              w_ram_wr;
    logic              w_wr_count;
    logic              w_wr_cmp;
    logic              w_wr_stat;
    logic              w_wr_gpio;
    logic [31:0]       w_mmio_rdata;
    logic [31:0]       w_count;
    logic [31:0]       w_cmp;
    logic              w_pending;
    logic              w_enable;
    logic              w_unused_addr_bits;

    // Upper RAM address bits alias; byte offset is ignored for word access
    assign w_unused_addr_bits = ^{ram_addr_i[27:RAM_AW+2], ram_addr_i[1:0]};

    // Region decode and write strobes; rst suppresses every write
    always_comb begin
        w_access    = |ram_ce_i;
        w_region    = (ram_addr_i[31:28] == MMIO_TAG) ? REGION_MMIO : REGION_RAM;
        w_word_idx  = ram_addr_i[RAM_AW+1:2];
        w_mmio_word = ram_addr_i[7:2];
        w_store     = w_access && ram_we_i && !rst;
        w_ram_wr    = w_store && (w_region == REGION_RAM);
        w_wr_count  = w_store && (w_region == REGION_MMIO) && (w_mmio_word == c_timer_count_off[7:2]);
        w_wr_cmp    = w_store && (w_region == REGION_MMIO) && (w_mmio_word == c_timer_cmp_off[7:2]);
        w_wr_stat   = w_store && (w_region == REGION_MMIO) && (w_mmio_word == c_timer_stat_off[7:2]);
        w_wr_gpio   = w_store && (w_region == REGION_MMIO) && (w_mmio_word == c_gpio_out_off[7:2]);
    end

    // RAM byte-lane write; contents survive reset
    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            r_mem[w_word_idx] <= lane_merge(r_mem[w_word_idx], ram_data_i, ram_sel_i);
        end
    end

    // GPIO output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gpio <= 32'h0;
        end else if (w_wr_gpio) begin
            r_gpio <= lane_merge(r_gpio, ram_data_i, ram_sel_i);
        end
    end

    data_mem_responder_mmio_timer #(
        .TIMER_RST (TIMER_RST)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .wr_count  (w_wr_count),
        .wr_cmp    (w_wr_cmp),
        .wr_stat   (w_wr_stat),
        .sel       (ram_sel_i),
        .wdata     (ram_data_i),
        .count     (w_count),
        .cmp       (w_cmp),
        .pending   (w_pending),
        .enable    (w_enable),
        .timer_irq (timer_irq_o)
    );

    // MMIO register read mux; unmapped offsets read zero
    always_comb begin
        w_mmio_rdata = 32'h0;
        if (w_mmio_word == c_timer_count_off[7:2]) begin
            w_mmio_rdata = w_count;
        end else if (w_mmio_word == c_timer_cmp_off[7:2]) begin
            w_mmio_rdata = w_cmp;
        end else if (w_mmio_word == c_timer_stat_off[7:2]) begin
            w_mmio_rdata[c_stat_pend_bit] = w_pending;
            w_mmio_rdata[c_stat_en_bit]   = w_enable;
        end else if (w_mmio_word == c_gpio_out_off[7:2]) begin
            w_mmio_rdata = r_gpio;
        end
    end

    // Load data: zero unless a load is in progress; RAM read is pre-write
    always_comb begin
        ram_data_o = 32'h0;
        if (!rst && w_access && !ram_we_i) begin
            ram_data_o = (w_region == REGION_MMIO) ? w_mmio_rdata : r_mem[w_word_idx];
        end
    end

    assign gpio_o = r_gpio;

endmodule : data_mem_responder
`default_nettype wire
